// File: rtl/poly_interp_fir.sv
// Polyphase interpolation FIR: every accepted input sample produces PHASES outputs,
// each the dot product of one coefficient phase with the last TAPS input samples.
module poly_interp_fir #(
  parameter  int IN_W   = 11,
  parameter  int COEF_W = 10,
  parameter  int TAPS   = 4,
  parameter  int PHASES = 4,
  parameter  int OUT_W  = 20,
  parameter  int SHIFT  = 0,
  localparam int PH_W   = $clog2(PHASES),
  localparam int AW     = $clog2(PHASES * TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [IN_W-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PH_W-1:0]          out_phase,
  output logic                     out_last,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     flush
);

  localparam int ACC_W  = IN_W + COEF_W + $clog2(TAPS);
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND     = (SHIFT > 0) ? ((ACC_W+1)'(1) <<< RND_SH) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic signed [IN_W-1:0]    x_q [TAPS];
  logic signed [IN_W-1:0]    x_d [TAPS];
  logic signed [COEF_W-1:0]  coef_q [PHASES][TAPS];
  logic signed [COEF_W-1:0]  coef_d [PHASES][TAPS];
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic [PH_W-1:0]           out_phase_q, out_phase_d;
  logic                      out_last_q, out_last_d;
  logic                      handshake_s, accept_s, advance_s, load_s;
  logic [PH_W-1:0]           calc_phase_s;
  logic signed [ACC_W-1:0]   acc_s;
  logic signed [ACC_W:0]     rnd_s;
  logic signed [OUT_W-1:0]   sat_s;

  assign out_valid    = (state_q == RUN);
  assign out_data     = out_data_q;
  assign out_phase    = out_phase_q;
  assign out_last     = out_last_q;
  assign handshake_s  = out_valid && out_ready;
  // A new sample may enter while idle or in the very cycle the last phase leaves.
  assign in_ready     = !flush && ((state_q == IDLE) || (handshake_s && out_last_q));
  assign accept_s     = in_valid && in_ready;
  assign advance_s    = handshake_s && !out_last_q;
  assign calc_phase_s = advance_s ? out_phase_q + PH_W'(1) : '0;

  // Delay line: flush wins over a shift.
  always_comb begin
    x_d = x_q;
    if (flush) begin
      for (int k = 0; k < TAPS; k++) x_d[k] = '0;
    end else if (accept_s) begin
      x_d[0] = in_data;
      for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
    end else begin
      x_d = x_q;
    end
  end

  // Coefficient RAM write port.
  always_comb begin
    coef_d = coef_q;
    for (int p = 0; p < PHASES; p++) begin
      for (int t = 0; t < TAPS; t++) begin
        if (coef_we && (coef_addr == AW'(p * TAPS + t))) coef_d[p][t] = coef_data;
        else                                              coef_d[p][t] = coef_q[p][t];
      end
    end
  end

  // Dot product on the updated line, rounding shift, saturation.
  always_comb begin
    acc_s = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_s = acc_s + ACC_W'(coef_q[calc_phase_s][k]) * ACC_W'(x_d[k]);
    end
    rnd_s = ((ACC_W+1)'(acc_s) + RND) >>> SHIFT;
    if (rnd_s > SAT_MAX)      sat_s = SAT_MAX[OUT_W-1:0];
    else if (rnd_s < SAT_MIN) sat_s = SAT_MIN[OUT_W-1:0];
    else                      sat_s = rnd_s[OUT_W-1:0];
  end

  // Next-state and output register loading.
  always_comb begin
    state_d     = state_q;
    load_s      = 1'b0;
    out_data_d  = out_data_q;
    out_phase_d = out_phase_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = RUN;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (advance_s || accept_s) load_s  = 1'b1;
        else if (handshake_s)      state_d = IDLE;
        else                       state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (load_s) begin
      out_data_d  = sat_s;
      out_phase_d = calc_phase_s;
      out_last_d  = (calc_phase_s == PH_W'(PHASES - 1));
    end else begin
      out_data_d  = out_data_q;
      out_phase_d = out_phase_q;
      out_last_d  = out_last_q;
    end
  end

  // State, delay line, coefficients and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '{default: '0};
      coef_q      <= '{default: '{default: '0}};
      out_data_q  <= '0;
      out_phase_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
      out_data_q  <= out_data_d;
      out_phase_q <= out_phase_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_poly_interp_fir.sv
// Directed plus randomized bench for poly_interp_fir; expected outputs come from a
// sample-history / coefficient-table model producing PHASES results per accepted sample.
module tb_poly_interp_fir;

  localparam int IN_W = 11, COEF_W = 10, TAPS = 4, PHASES = 4, OUT_W = 20, SHIFT = 0;
  localparam int PH_W = $clog2(PHASES), AW = $clog2(PHASES * TAPS);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic signed [IN_W-1:0]   in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [PH_W-1:0]          out_phase;
  logic                     out_last;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     flush;

  poly_interp_fir #(.IN_W(IN_W), .COEF_W(COEF_W), .TAPS(TAPS), .PHASES(PHASES),
                    .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_phase(out_phase),
    .out_last(out_last), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .flush(flush));

  always #5 clk = ~clk;

  typedef struct {longint data; int phase;} exp_t;
  exp_t   sb[$];
  longint obs_log[$];
  longint hist [TAPS];
  longint cf [PHASES][TAPS];
  int     n_checks = 0;
  int     n_pass = 0;
  int     acc_count = 0;
  int     valid_seen = 0;
  bit     accepted;

  function automatic longint ref_out(int p);
    longint acc = 0;
    longint lim = longint'(1) << (OUT_W - 1);
    for (int k = 0; k < TAPS; k++) acc += cf[p][k] * hist[k];
    if (SHIFT > 0) acc = (acc + (longint'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0))) >>> SHIFT;
    if (acc > lim - 1)   acc = lim - 1;
    else if (acc < -lim) acc = -lim;
    return acc;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: check outputs against the model, advance the model, wait for next negedge.
  task automatic cycle();
    bit exp_ready;
    #1;
    if (!rst_n) begin
      sb.delete();
      for (int k = 0; k < TAPS; k++) hist[k] = 0;
      for (int p = 0; p < PHASES; p++) for (int t = 0; t < TAPS; t++) cf[p][t] = 0;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_phase", out_phase, 0);
      chk("rst_last", out_last, 0);
      chk("rst_in_ready", in_ready, 1);
      accepted = 1'b0;
    end else begin
      exp_ready = !flush && (sb.size() == 0 || (sb.size() == 1 && out_ready));
      chk("out_valid", out_valid, sb.size() > 0);
      if (sb.size() > 0) begin
        valid_seen++;
        chk("out_data", out_data, sb[0].data);
        chk("out_phase", out_phase, sb[0].phase);
        chk("out_last", out_last, sb[0].phase == PHASES - 1);
      end
      chk("in_ready", in_ready, exp_ready);
      accepted = in_valid && exp_ready;
      if (sb.size() > 0 && out_ready) begin
        obs_log.push_back(longint'(out_data));
        void'(sb.pop_front());
      end
      if (flush) begin
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
      end else if (accepted) begin
        acc_count++;
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(in_data);
        for (int p = 0; p < PHASES; p++) sb.push_back('{data: ref_out(p), phase: p});
      end
      if (coef_we) cf[int'(coef_addr) / TAPS][int'(coef_addr) % TAPS] = longint'(coef_data);
    end
    @(negedge clk);
  endtask

  task automatic wcoef(input int p, input int t, input int v);
    coef_we = 1'b1; coef_addr = AW'(p * TAPS + t); coef_data = COEF_W'(v);
    cycle();
    coef_we = 1'b0;
  endtask

  task automatic load_impulse_coefs();
    for (int p = 0; p < PHASES; p++) for (int t = 0; t < TAPS; t++) wcoef(p, t, (t == 0) ? p + 1 : 0);
  endtask

  task automatic push(input int v);
    bit got = 1'b0;
    in_valid = 1'b1; in_data = IN_W'(v);
    for (int i = 0; i < 64 && !got; i++) begin
      cycle();
      got = accepted;
    end
    chk("accept_timeout", got, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() > 0; i++) cycle();
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; flush = 1'b0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;

    // Impulse through phase p = {p+1,0,0,0}
    load_impulse_coefs();
    obs_log.delete();
    push(1);
    for (int i = 0; i < 4; i++) push(0);
    drain();
    chk("t1_count", obs_log.size(), 20);
    for (int i = 0; i < 4; i++) chk("t1_imp", obs_log[i], i + 1);
    for (int i = 4; i < 8; i++) chk("t1_zero", obs_log[i], 0);

    // Step response of phase 0
    for (int p = 0; p < PHASES; p++) for (int t = 0; t < TAPS; t++) wcoef(p, t, 0);
    wcoef(0, 0, 20); wcoef(0, 1, 284); wcoef(0, 2, 204); wcoef(0, 3, 4);
    obs_log.delete();
    for (int i = 0; i < 4; i++) push(100);
    drain();
    chk("t2_s0", obs_log[0], 2000);
    chk("t2_s1", obs_log[4], 30400);
    chk("t2_s2", obs_log[8], 50800);
    chk("t2_s3", obs_log[12], 51200);

    // Negative saturation
    for (int p = 0; p < PHASES; p++) for (int t = 0; t < TAPS; t++) wcoef(p, t, 511);
    obs_log.delete();
    for (int i = 0; i < 4; i++) push(-1024);
    drain();
    chk("t3_sat", obs_log[15], -524288);

    // Back-pressure mid-sample with a pending input
    obs_log.delete();
    push(7);
    idle(1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = IN_W'(5);
    idle(3);
    out_ready = 1'b1;
    push(5);
    drain();
    chk("t4_count", obs_log.size(), 8);

    // Full rate with in_valid held
    acc_count = 0; valid_seen = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = IN_W'(int'($urandom_range(0, 2047)) - 1024);
      cycle();
    end
    in_valid = 1'b0;
    chk("t5_accepts", acc_count, 5);
    chk("t5_valid", valid_seen, 16);
    drain();

    // Random traffic; coef writes and flushes only between samples
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = IN_W'(int'($urandom_range(0, 2047)) - 1024);
      if (sb.size() == 0 && $urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          flush = 1'b1;
        end else begin
          in_valid = 1'b0;
          coef_we = 1'b1;
          coef_addr = AW'($urandom_range(0, PHASES * TAPS - 1));
          coef_data = COEF_W'(int'($urandom_range(0, 1023)) - 512);
        end
      end
      cycle();
      flush = 1'b0; coef_we = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset during phase 2, then flush and repeat the impulse
    load_impulse_coefs();
    push(3);
    idle(2);
    chk("t6_phase", out_phase, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_phase", out_phase, 0);
    chk("t6_rst_ready", in_ready, 1);
    cycle();
    rst_n = 1'b1;
    load_impulse_coefs();
    push(9); push(-4);
    drain();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    obs_log.delete();
    push(1);
    drain();
    for (int i = 0; i < 4; i++) chk("t6_imp", obs_log[i], i + 1);

    chk("final_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
